// File: rtl/audio_channel_bank.sv
// audio_channel_bank
// Bank of square-wave tone channels stepped by an external base-rate tick.
// Each channel has a programmable divider, optional poly-noise gating, a
// 4-bit volume and a volume-only (DC) mode. Odd channels can absorb their
// even neighbour to form one double-width divider for low frequencies.
// The gated channel levels are summed into a registered mix value which
// also drives a simple free-running PWM output.

module audio_channel_bank #(
   parameter  int NUM_CH = 4,
   parameter  int DIV_W  = 8,
   localparam int MIX_W  = 4 + $clog2(NUM_CH),
   localparam int AW     = $clog2(NUM_CH) + 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              tick,
   input  logic              noise_in,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DIV_W-1:0]  wr_data,
   output logic [NUM_CH-1:0] ch_level,
   output logic [MIX_W-1:0]  mix,
   output logic              pwm_out
);

   localparam int NUM_PAIR = NUM_CH / 2;
   localparam int CH_W     = AW - 1;

   localparam logic [DIV_W-1:0]   DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [2*DIV_W-1:0] PAIR_ONE = {{(2*DIV_W-1){1'b0}}, 1'b1};
   localparam logic [MIX_W-1:0]   MIX_ONE  = {{(MIX_W-1){1'b0}}, 1'b1};

   // CTL register bit positions
   localparam int VOL_ONLY = 4;
   localparam int NOISE_EN = 5;
   localparam int LINK     = 6;
   localparam int ENABLE   = 7;

   logic [DIV_W-1:0]    freq_q [NUM_CH];
   logic [DIV_W-1:0]    freq_d [NUM_CH];
   logic [7:0]          ctl_q  [NUM_CH];
   logic [7:0]          ctl_d  [NUM_CH];
   logic [DIV_W-1:0]    cnt_q  [NUM_CH];
   logic [DIV_W-1:0]    cnt_d  [NUM_CH];
   logic [NUM_CH-1:0]   wave_q, wave_d;
   logic [NUM_CH-1:0]   latch_q, latch_d;
   logic [NUM_PAIR-1:0] linkApp_q, linkApp_d;
   logic [MIX_W-1:0]    mix_q, mix_d;
   logic [MIX_W-1:0]    pwmCnt_q, pwmCnt_d;
   logic                pwmOut_q, pwmOut_d;
   logic [NUM_CH-1:0]   level;
   logic [CH_W-1:0]     wrCh;
   logic                wrSel;

   assign wrCh  = wr_addr[AW-1:1];
   assign wrSel = wr_addr[0];

   // Register file update: the addressed FREQ or CTL takes the write data;
   // addresses beyond the last channel match no entry and are dropped.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         freq_d[c] = freq_q[c];
         ctl_d[c]  = ctl_q[c];
         if (wr_en && (int'(wrCh) == c)) begin
            if (wrSel) begin
               ctl_d[c] = wr_data[7:0];
            end else begin
               freq_d[c] = wr_data;
            end
         end
      end
   end

   // Divider, square wave and noise latch. Every channel first gets the
   // stand-alone behaviour, then pairs whose link state is changing or
   // already active override it. A link change is only applied on a tick,
   // and at that moment both halves restart from their own FREQ with the
   // waves left as they were. Reloads always use the stored (pre-write) FREQ.
   always_comb begin
      linkApp_d = linkApp_q;
      for (int c = 0; c < NUM_CH; c++) begin
         cnt_d[c]   = cnt_q[c];
         wave_d[c]  = wave_q[c];
         latch_d[c] = latch_q[c];
         if (!ctl_q[c][ENABLE]) begin
            cnt_d[c]  = freq_q[c];
            wave_d[c] = 1'b0;
         end else if (tick) begin
            if (cnt_q[c] == '0) begin
               cnt_d[c]   = freq_q[c];
               wave_d[c]  = ~wave_q[c];
               latch_d[c] = noise_in;
            end else begin
               cnt_d[c] = cnt_q[c] - DIV_ONE;
            end
         end
      end
      for (int p = 0; p < NUM_PAIR; p++) begin
         if (tick && (ctl_q[2*p+1][LINK] != linkApp_q[p])) begin
            cnt_d[2*p]     = freq_q[2*p];
            cnt_d[2*p+1]   = freq_q[2*p+1];
            wave_d[2*p]    = wave_q[2*p];
            wave_d[2*p+1]  = wave_q[2*p+1];
            latch_d[2*p]   = latch_q[2*p];
            latch_d[2*p+1] = latch_q[2*p+1];
            linkApp_d[p]   = ctl_q[2*p+1][LINK];
         end else if (linkApp_q[p]) begin
            cnt_d[2*p]     = cnt_q[2*p];
            cnt_d[2*p+1]   = cnt_q[2*p+1];
            wave_d[2*p]    = 1'b0;
            wave_d[2*p+1]  = wave_q[2*p+1];
            latch_d[2*p]   = latch_q[2*p];
            latch_d[2*p+1] = latch_q[2*p+1];
            if (!ctl_q[2*p+1][ENABLE]) begin
               cnt_d[2*p]    = freq_q[2*p];
               cnt_d[2*p+1]  = freq_q[2*p+1];
               wave_d[2*p+1] = 1'b0;
            end else if (tick) begin
               if ({cnt_q[2*p+1], cnt_q[2*p]} == '0) begin
                  cnt_d[2*p]     = freq_q[2*p];
                  cnt_d[2*p+1]   = freq_q[2*p+1];
                  wave_d[2*p+1]  = ~wave_q[2*p+1];
                  latch_d[2*p+1] = noise_in;
               end else begin
                  {cnt_d[2*p+1], cnt_d[2*p]} = {cnt_q[2*p+1], cnt_q[2*p]} - PAIR_ONE;
               end
            end
         end
      end
   end

   // Channel output level: volume-only forces the level high, otherwise the
   // wave optionally gated by the latched noise bit. A disabled channel or
   // the low half of a linked pair is always silent.
   always_comb begin
      level = '0;
      for (int p = 0; p < NUM_PAIR; p++) begin
         level[2*p] = ctl_q[2*p][ENABLE] & ~ctl_q[2*p+1][LINK] &
                      (ctl_q[2*p][VOL_ONLY] |
                       (wave_q[2*p] & (~ctl_q[2*p][NOISE_EN] | latch_q[2*p])));
         level[2*p+1] = ctl_q[2*p+1][ENABLE] &
                        (ctl_q[2*p+1][VOL_ONLY] |
                         (wave_q[2*p+1] & (~ctl_q[2*p+1][NOISE_EN] | latch_q[2*p+1])));
      end
   end

   // Mixer and PWM: sum the volumes of every channel currently high, and
   // compare a free-running counter against the registered sum.
   always_comb begin
      mix_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (level[c]) begin
            mix_d = mix_d + {{(MIX_W-4){1'b0}}, ctl_q[c][3:0]};
         end
      end
      pwmCnt_d = pwmCnt_q + MIX_ONE;
      pwmOut_d = (pwmCnt_q < mix_q);
   end

   // State registers; clr wins over writes and ticks in the same cycle.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int c = 0; c < NUM_CH; c++) begin
            freq_q[c] <= '0;
            ctl_q[c]  <= '0;
            cnt_q[c]  <= '0;
         end
         wave_q    <= '0;
         latch_q   <= '0;
         linkApp_q <= '0;
         mix_q     <= '0;
         pwmCnt_q  <= '0;
         pwmOut_q  <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            freq_q[c] <= freq_d[c];
            ctl_q[c]  <= ctl_d[c];
            cnt_q[c]  <= cnt_d[c];
         end
         wave_q    <= wave_d;
         latch_q   <= latch_d;
         linkApp_q <= linkApp_d;
         mix_q     <= mix_d;
         pwmCnt_q  <= pwmCnt_d;
         pwmOut_q  <= pwmOut_d;
      end
   end

   assign ch_level = level;
   assign mix      = mix_q;
   assign pwm_out  = pwmOut_q;

endmodule

// File: tb/tb_audio_channel_bank.sv
// tb_audio_channel_bank
// Directed bench for audio_channel_bank: a table of static register
// configurations plus hand-built tick sequences for the timing corners.
// A second, six-channel instance covers out-of-range write addresses.

module tb_audio_channel_bank;

   logic       clk;
   logic       clr;
   logic       tick;
   logic       noise_in;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] ch_level;
   logic [5:0] mix;
   logic       pwm_out;

   logic       wr_en6;
   logic [3:0] wr_addr6;
   logic [5:0] ch_level6;
   logic [6:0] mix6;
   logic       pwm_out6;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      logic [1:0] ch;
      logic [7:0] ctl;
      logic [3:0] expLevel;
      logic [5:0] expMix;
   } vec_t;

   vec_t vecs [8];

   audio_channel_bank #(.NUM_CH(4), .DIV_W(8)) dut (
      .clk      (clk),
      .clr      (clr),
      .tick     (tick),
      .noise_in (noise_in),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .ch_level (ch_level),
      .mix      (mix),
      .pwm_out  (pwm_out)
   );

   audio_channel_bank #(.NUM_CH(6), .DIV_W(8)) dut6 (
      .clk      (clk),
      .clr      (clr),
      .tick     (tick),
      .noise_in (noise_in),
      .wr_en    (wr_en6),
      .wr_addr  (wr_addr6),
      .wr_data  (wr_data),
      .ch_level (ch_level6),
      .mix      (mix6),
      .pwm_out  (pwm_out6)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end else begin
         passCount++;
      end
   endtask

   task automatic writeReg(input logic [1:0] ch, input logic sel, input logic [7:0] data);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = {ch, sel};
      wr_data = data;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic writeReg6(input logic [2:0] ch, input logic sel, input logic [7:0] data);
      @(negedge clk);
      wr_en6   = 1'b1;
      wr_addr6 = {ch, sel};
      wr_data  = data;
      @(negedge clk);
      wr_en6 = 1'b0;
   endtask

   task automatic applyStimulus(input int n);
      @(negedge clk);
      tick = 1'b1;
      repeat (n) @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic pulseClear();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   // Main test sequence
   initial begin
      int expL;
      int prevMix;
      int highCount;

      vecs[0] = '{2'd2, 8'h9A, 4'b0100, 6'd10};
      vecs[1] = '{2'd0, 8'h93, 4'b0101, 6'd13};
      vecs[2] = '{2'd1, 8'h9F, 4'b0111, 6'd28};
      vecs[3] = '{2'd3, 8'h9F, 4'b1111, 6'd43};
      vecs[4] = '{2'd3, 8'h1F, 4'b0111, 6'd28};
      vecs[5] = '{2'd1, 8'hDF, 4'b0110, 6'd25};
      vecs[6] = '{2'd1, 8'h00, 4'b0101, 6'd13};
      vecs[7] = '{2'd2, 8'h8A, 4'b0001, 6'd3};

      clr      = 1'b1;
      tick     = 1'b0;
      noise_in = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      wr_en6   = 1'b0;
      wr_addr6 = '0;
      repeat (3) @(negedge clk);
      clr = 1'b0;

      checkOutput("reset_level", 32'(ch_level), 0);
      checkOutput("reset_mix", 32'(mix), 0);
      checkOutput("reset_pwm", 32'(pwm_out), 0);

      // Static volume-only configurations applied one after another
      for (int i = 0; i < 8; i++) begin
         writeReg(vecs[i].ch, 1'b1, vecs[i].ctl);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_level", i), 32'(ch_level), 32'(vecs[i].expLevel));
         checkOutput($sformatf("vec%0d_mix", i), 32'(mix), 32'(vecs[i].expMix));
      end

      // clr with every register loaded, and a write in the clr cycle
      pulseClear();
      for (int c = 0; c < 4; c++) begin
         writeReg(2'(c), 1'b0, 8'h33);
         writeReg(2'(c), 1'b1, 8'h9F);
      end
      @(negedge clk);
      checkOutput("preclr_mix", 32'(mix), 60);
      @(negedge clk);
      clr     = 1'b1;
      wr_en   = 1'b1;
      wr_addr = {2'd0, 1'b1};
      wr_data = 8'h9F;
      tick    = 1'b1;
      @(negedge clk);
      clr   = 1'b0;
      wr_en = 1'b0;
      tick  = 1'b0;
      checkOutput("clr_level", 32'(ch_level), 0);
      checkOutput("clr_mix", 32'(mix), 0);
      checkOutput("clr_pwm", 32'(pwm_out), 0);
      repeat (3) @(negedge clk);
      checkOutput("clr_mix_hold", 32'(mix), 0);
      checkOutput("clr_pwm_hold", 32'(pwm_out), 0);
      writeReg(2'd0, 1'b1, 8'h81);
      applyStimulus(1);
      checkOutput("clr_freq0_t1", 32'(ch_level[0]), 1);
      applyStimulus(1);
      checkOutput("clr_freq0_t2", 32'(ch_level[0]), 0);

      // Plain tone: FREQ=3 toggles every 4 ticks, mix follows one clk later
      pulseClear();
      writeReg(2'd0, 1'b0, 8'd3);
      writeReg(2'd0, 1'b1, 8'h8F);
      prevMix = 0;
      for (int n = 1; n <= 12; n++) begin
         applyStimulus(1);
         expL = (n / 4) % 2;
         checkOutput($sformatf("tone_t%0d_level", n), 32'(ch_level[0]), 32'(expL));
         checkOutput($sformatf("tone_t%0d_mix_lag", n), 32'(mix), 32'(prevMix));
         @(negedge clk);
         prevMix = (expL != 0) ? 15 : 0;
         checkOutput($sformatf("tone_t%0d_mix", n), 32'(mix), 32'(prevMix));
         @(negedge clk);
      end

      // Linked pair: 16-bit reload 0x0100 gives a 257-tick half period
      pulseClear();
      writeReg(2'd1, 1'b0, 8'h01);
      writeReg(2'd0, 1'b0, 8'h00);
      writeReg(2'd1, 1'b1, 8'hC5);
      applyStimulus(257);
      checkOutput("link_t257", 32'(ch_level), 0);
      applyStimulus(1);
      checkOutput("link_t258", 32'(ch_level), 2);
      @(negedge clk);
      checkOutput("link_mix_high", 32'(mix), 5);
      applyStimulus(256);
      checkOutput("link_t514", 32'(ch_level), 2);
      applyStimulus(1);
      checkOutput("link_t515", 32'(ch_level), 0);
      @(negedge clk);
      checkOutput("link_mix_low", 32'(mix), 0);
      writeReg(2'd0, 1'b1, 8'h81);
      @(negedge clk);
      checkOutput("link_low_excluded", 32'(ch_level[0]), 0);
      writeReg(2'd1, 1'b1, 8'h85);
      applyStimulus(1);
      checkOutput("unlink_t1", 32'(ch_level), 0);
      applyStimulus(1);
      checkOutput("unlink_t2", 32'(ch_level), 1);
      applyStimulus(1);
      checkOutput("unlink_t3", 32'(ch_level), 2);
      applyStimulus(1);
      checkOutput("unlink_t4", 32'(ch_level), 3);
      applyStimulus(1);
      checkOutput("unlink_t5", 32'(ch_level), 0);

      // Volume-only PWM: mix 10 of a 64-clk frame
      pulseClear();
      writeReg(2'd2, 1'b1, 8'h9A);
      repeat (2) @(negedge clk);
      checkOutput("pwm_mix", 32'(mix), 10);
      highCount = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (pwm_out) highCount++;
      end
      checkOutput("pwm_high_count", 32'(highCount), 10);

      // Noise gating: latched only at toggles
      pulseClear();
      writeReg(2'd0, 1'b0, 8'd1);
      writeReg(2'd0, 1'b1, 8'hA8);
      noise_in = 1'b0;
      applyStimulus(2);
      checkOutput("noise0_gated", 32'(ch_level[0]), 0);
      noise_in = 1'b1;
      applyStimulus(2);
      checkOutput("noise1_wave_low", 32'(ch_level[0]), 0);
      applyStimulus(2);
      checkOutput("noise1_wave_high", 32'(ch_level[0]), 1);
      @(negedge clk);
      checkOutput("noise1_mix", 32'(mix), 8);
      noise_in = 1'b0;
      applyStimulus(1);
      checkOutput("noise_hold_latch", 32'(ch_level[0]), 1);
      applyStimulus(1);
      checkOutput("noise_next_toggle", 32'(ch_level[0]), 0);

      // FREQ write coincident with the underflow tick
      pulseClear();
      writeReg(2'd0, 1'b0, 8'd2);
      writeReg(2'd0, 1'b1, 8'h8F);
      applyStimulus(2);
      checkOutput("coinc_pre", 32'(ch_level[0]), 0);
      @(negedge clk);
      tick    = 1'b1;
      wr_en   = 1'b1;
      wr_addr = {2'd0, 1'b0};
      wr_data = 8'd5;
      @(negedge clk);
      tick  = 1'b0;
      wr_en = 1'b0;
      checkOutput("coinc_toggle", 32'(ch_level[0]), 1);
      applyStimulus(2);
      checkOutput("coinc_old_t2", 32'(ch_level[0]), 1);
      applyStimulus(1);
      checkOutput("coinc_old_t3", 32'(ch_level[0]), 0);
      applyStimulus(5);
      checkOutput("coinc_new_t5", 32'(ch_level[0]), 0);
      applyStimulus(1);
      checkOutput("coinc_new_t6", 32'(ch_level[0]), 1);

      // Out-of-range channel addresses on the six-channel instance
      pulseClear();
      writeReg6(3'd7, 1'b0, 8'h11);
      writeReg6(3'd7, 1'b1, 8'h9F);
      writeReg6(3'd6, 1'b1, 8'h9F);
      @(negedge clk);
      checkOutput("oor_level", 32'(ch_level6), 0);
      checkOutput("oor_mix", 32'(mix6), 0);
      writeReg6(3'd5, 1'b1, 8'h9F);
      @(negedge clk);
      checkOutput("ch5_level", 32'(ch_level6), 32);
      checkOutput("ch5_mix", 32'(mix6), 15);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
